// File: rtl/tiny_dmem.sv
`default_nettype none
// ============================================================================
// Module  : tiny_dmem
// Purpose : Single-port data memory responder for LW/SW with configurable
//           wait states; optional LED register enabled by DMEM_MMIO_LED_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tiny_dmem #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] LED_ADDR    = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [2:0]  led_rgb
);

  localparam int          c_idx_w     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] c_mem_bytes = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  c_wait_init = 4'(WAIT_STATES - 1);
`ifdef DMEM_MMIO_LED_EN
  localparam logic        c_led_en    = 1'b1;
`else
  localparam logic        c_led_en    = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic               w_accept;
  logic               w_enter_resp;
  logic               w_we;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;
  logic [3:0]         w_be;
  logic [c_idx_w-1:0] w_idx;
  logic               w_in_mem;
  logic               w_is_led;
  logic               w_err;
  logic               w_do_store;
  logic [2:0]         w_led;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= c_wait_init;
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // With zero wait states the access happens on the accept edge itself,
  // so the live request is used instead of the not-yet-latched copy.
  assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_be    = (r_state == S_IDLE) ? req_be    : r_be;

  assign w_idx        = w_addr[c_idx_w+1:2];
  assign w_in_mem     = (w_addr < c_mem_bytes);
  assign w_is_led     = c_led_en && (w_addr == LED_ADDR);
  assign w_err        = (w_addr[1:0] != 2'b00) || (!w_in_mem && !w_is_led);
  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
  // Reset is folded in so a request pending during reset never commits.
  assign w_do_store   = RST_N && w_enter_resp && w_we && !w_err;

  always_ff @(posedge CLK) begin
    if (w_do_store && w_in_mem) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (w_enter_resp) begin
      rsp_err <= w_err;
      if (w_err || w_we) rsp_rdata <= '0;
      else if (w_is_led) rsp_rdata <= {29'b0, w_led};
      else               rsp_rdata <= r_mem[w_idx];
    end else begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

`ifdef DMEM_MMIO_LED_EN
  logic [2:0] r_led;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_led <= 3'b000;
    else if (w_do_store && w_is_led && w_be[0]) r_led <= w_wdata[2:0];
  end

  assign w_led = r_led;
`else
  assign w_led = 3'b000;
`endif

  assign led_rgb = w_led;

endmodule
`default_nettype wire

// File: doc/tiny_dmem.md
# tiny_dmem

Single-port data memory responder for the tiny CPU's load/store path: it accepts one LW/SW request at a time over a valid/ready handshake, inserts a configurable number of wait states, then returns a one-cycle response. It sits between the CPU's memory stage and the board, and optionally exposes a memory-mapped RGB LED register so stored values are visible on the LEDs.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words; byte address range 0 .. DEPTH_WORDS*4-1.
- WAIT_STATES, 1: idle cycles between accept and response; 0..15 legal.
- LED_ADDR, 32'h0000_0100: byte address of the LED register (used only with DMEM_MMIO_LED_EN).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_N  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; ignored for loads.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: misaligned or unmapped access.
- led_rgb  out  3  {red, green, blue} LED register.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch we/addr/wdata/be; go to WAIT if WAIT_STATES>0, else RESP.
- WAIT: 4-bit counter loaded with WAIT_STATES-1 at accept; decrement each cycle; at 0 go to RESP.
- Access is performed on the edge entering RESP: read word sampled into rsp_rdata, or write committed per byte enable.
- RESP: rsp_valid=1 for exactly one cycle; next state IDLE. No response backpressure.
- Decode: word index = addr[31:2]. Error if addr[1:0] != 0, or if addr >= DEPTH_WORDS*4 and addr is not an enabled LED register.
- Errored store: no memory or LED change. Errored load: rsp_rdata=0. rsp_err=1 in both cases.
- Store with req_be=4'b0000: legal, no change, rsp_err=0.
- req_valid while not IDLE is ignored. The CPU must hold the request until it sees req_ready.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, led_rgb=0, state IDLE.
- Latency: rsp_valid is high in cycle N+WAIT_STATES+1, where N is the accept cycle.
- Throughput: one request per WAIT_STATES+2 cycles; req_ready is low from N+1 through the RESP cycle.
- Reset asserted mid-transaction: the in-flight request is discarded, no response is produced, and an uncommitted store is dropped.
- Store followed by load to the same address: the load returns the new data, because the store is committed before IDLE is re-entered.
- rsp_rdata and rsp_err return to 0 in the cycle after RESP.

## Configuration
- DMEM_MMIO_LED_EN defined:
  - LED_ADDR decodes to the LED register.
  - A store with req_be[0]=1 sets led_rgb <= req_wdata[2:0].
  - A load returns {29'b0, led_rgb}.
  - LED_ADDR must lie outside the memory range.
- DMEM_MMIO_LED_EN undefined:
  - No LED register exists.
  - LED_ADDR is decoded like any other address; with default parameters it is unmapped and returns rsp_err=1.
  - led_rgb is tied to 3'b000.

## Test plan
- Reset, WAIT_STATES=1: SW addr 0x0, wdata 0x2A, be 4'hF, accepted at cycle N -> rsp_valid at N+2, rsp_err=0. Then LW 0x0 -> rsp_rdata=0x0000_002A.
- Byte enables: SW 0x4 with 0xFFFF_FFFF, then SW 0x4 with 0x0000_0012 and be 4'b0001; LW 0x4 -> 0xFFFF_FF12.
- Errors: LW 0x2 -> rsp_err=1, rsp_rdata=0. SW 0x100 without the macro -> rsp_err=1.
- Macro on: SW 0x100 with wdata 0x5 -> led_rgb=3'b101; LW 0x100 -> 0x5.
- Reset mid-op: WAIT_STATES=4, SW 0x8 with 0x77; pulse RST_N low in the second WAIT cycle -> no rsp_valid, req_ready=1 and led_rgb=0 immediately.
- Back-to-back: hold req_valid during WAIT -> second request accepted only after IDLE is re-entered; exactly one rsp_valid pulse per request.
